// File: rtl/radio_ctrl_sync_seq.sv
// Multi-channel radio enable / RX enable sequencer: per-channel synchronizers, settle and drain
// timing, an isolation clamp for the power-domain boundary, and edge pulses for the timing engine.
module radio_ctrl_sync_seq #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int DRAIN_CYC   = 2
) (
    input  logic              ck,
    input  logic              arst,
    input  logic              isolate_i,
    input  logic [NUM_CH-1:0] radio_enable_async_i,
    input  logic [NUM_CH-1:0] radio_rx_en_async_i,
    output logic [NUM_CH-1:0] radio_enable_o,
    output logic [NUM_CH-1:0] radio_rx_en_o,
    output logic [NUM_CH-1:0] ready_o,
    output logic [NUM_CH-1:0] enable_rise_o,
    output logic [NUM_CH-1:0] enable_fall_o
);

    localparam int CNT_MAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] en_sync;
        logic [SYNC_STAGES-1:0] rx_sync;
        logic                   en_s;
        logic                   rx_s;
        state_t                 state;
        state_t                 state_nxt;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       cnt_nxt;
        logic                   rise;
        logic                   rise_nxt;
        logic                   fall;
        logic                   fall_nxt;

        // Synchronizer chains run regardless of isolation so en_s is current on release.
        always_ff @(posedge ck or posedge arst) begin
            if (arst) begin
                en_sync <= '0;
                rx_sync <= '0;
            end else begin
                en_sync <= {en_sync[SYNC_STAGES-2:0], radio_enable_async_i[c]};
                rx_sync <= {rx_sync[SYNC_STAGES-2:0], radio_rx_en_async_i[c]};
            end
        end

        assign en_s = en_sync[SYNC_STAGES-1];
        assign rx_s = rx_sync[SYNC_STAGES-1];

        always_ff @(posedge ck or posedge arst) begin
            if (arst) begin
                state <= ST_OFF;
                cnt   <= '0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                rise  <= rise_nxt;
                fall  <= fall_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            if (isolate_i) begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (en_s) begin
                            state_nxt = ST_SETTLE;
                            cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
                            rise_nxt  = 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        // RX was never granted, so an abort here skips the drain phase.
                        if (!en_s) begin
                            state_nxt = ST_OFF;
                            cnt_nxt   = '0;
                            fall_nxt  = 1'b1;
                        end else if (cnt == '0) begin
                            state_nxt = ST_ON;
                        end else begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (!en_s) begin
                            fall_nxt = 1'b1;
                            if (DRAIN_CYC > 0) begin
                                state_nxt = ST_DRAIN;
                                cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
                            end else begin
                                state_nxt = ST_OFF;
                                cnt_nxt   = '0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt == '0) begin
                            state_nxt = ST_OFF;
                        end else begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // Isolation clamps every output in the same cycle it is raised.
        assign radio_enable_o[c] = ~isolate_i & (state != ST_OFF);
        assign ready_o[c]        = ~isolate_i & (state == ST_ON);
        assign radio_rx_en_o[c]  = ~isolate_i & (state == ST_ON) & rx_s;
        assign enable_rise_o[c]  = ~isolate_i & rise;
        assign enable_fall_o[c]  = ~isolate_i & fall;
    end

endmodule

// File: tb/tb_radio_ctrl_sync_seq.sv
// Self-checking bench for radio_ctrl_sync_seq: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a timing-based channel model.
module tb_radio_ctrl_sync_seq;

    localparam int NUM_CH      = 2;
    localparam int SYNC_STAGES = 2;
    localparam int SETTLE_CYC  = 4;
    localparam int DRAIN_CYC   = 2;

    logic              ck = 1'b0;
    logic              arst;
    logic              isolate;
    logic [NUM_CH-1:0] en_a;
    logic [NUM_CH-1:0] rx_a;
    logic [NUM_CH-1:0] radio_enable;
    logic [NUM_CH-1:0] radio_rx_en;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] enable_rise;
    logic [NUM_CH-1:0] enable_fall;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 0;

    radio_ctrl_sync_seq #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .SETTLE_CYC  (SETTLE_CYC),
        .DRAIN_CYC   (DRAIN_CYC)
    ) dut (
        .ck                   (ck),
        .arst                 (arst),
        .isolate_i            (isolate),
        .radio_enable_async_i (en_a),
        .radio_rx_en_async_i  (rx_a),
        .radio_enable_o       (radio_enable),
        .radio_rx_en_o        (radio_rx_en),
        .ready_o              (ready),
        .enable_rise_o        (enable_rise),
        .enable_fall_o        (enable_fall)
    );

    always #5 ck = ~ck;

    // Channel model: "on" flag, cycles since enable rose, remaining drain cycles.
    bit m_on    [NUM_CH];
    int m_age   [NUM_CH];
    int m_drain [NUM_CH];
    bit m_rise  [NUM_CH];
    bit m_fall  [NUM_CH];
    bit en_hist [NUM_CH][SYNC_STAGES];
    bit rx_hist [NUM_CH][SYNC_STAGES];

    initial begin
        forever begin
            @(posedge ck or posedge arst);
            for (int c = 0; c < NUM_CH; c++) begin
                if (arst) begin
                    m_on[c] = 0; m_age[c] = 0; m_drain[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        en_hist[c][s] = 0;
                        rx_hist[c][s] = 0;
                    end
                end else begin
                    bit ens;
                    ens = en_hist[c][SYNC_STAGES-1];
                    m_rise[c] = 0;
                    m_fall[c] = 0;
                    if (isolate) begin
                        m_on[c] = 0; m_age[c] = 0; m_drain[c] = 0;
                    end else if (m_drain[c] > 0) begin
                        m_drain[c]--;
                        if (m_drain[c] == 0) m_on[c] = 0;
                    end else if (!m_on[c]) begin
                        if (ens) begin
                            m_on[c] = 1; m_age[c] = 0; m_rise[c] = 1;
                        end
                    end else if (!ens) begin
                        m_fall[c] = 1;
                        if (m_age[c] >= SETTLE_CYC && DRAIN_CYC > 0) m_drain[c] = DRAIN_CYC;
                        else m_on[c] = 0;
                    end else if (m_age[c] < SETTLE_CYC) begin
                        m_age[c]++;
                    end
                    for (int s = SYNC_STAGES - 1; s > 0; s--) begin
                        en_hist[c][s] = en_hist[c][s-1];
                        rx_hist[c][s] = rx_hist[c][s-1];
                    end
                    en_hist[c][0] = en_a[c];
                    rx_hist[c][0] = rx_a[c];
                end
            end
        end
    end

    task automatic check(input string name, input logic [NUM_CH-1:0] act,
                         input logic [NUM_CH-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    logic [NUM_CH-1:0] e_en, e_ready, e_rx, e_rise, e_fall;

    initial begin
        forever begin
            @(negedge ck);
            if (cmp_on) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    bit rdy;
                    rdy        = m_on[c] && m_drain[c] == 0 && m_age[c] >= SETTLE_CYC;
                    e_en[c]    = !isolate && !arst && m_on[c];
                    e_ready[c] = !isolate && !arst && rdy;
                    e_rx[c]    = !isolate && !arst && rdy && rx_hist[c][SYNC_STAGES-1];
                    e_rise[c]  = !isolate && !arst && m_rise[c];
                    e_fall[c]  = !isolate && !arst && m_fall[c];
                end
                check("model_enable", radio_enable, e_en);
                check("model_ready",  ready,        e_ready);
                check("model_rx",     radio_rx_en,  e_rx);
                check("model_rise",   enable_rise,  e_rise);
                check("model_fall",   enable_fall,  e_fall);
            end
        end
    end

    task automatic step();
        @(posedge ck);
        #2;
    endtask

    initial begin
        int iso_left;
        arst = 1'b0; isolate = 1'b0; en_a = '0; rx_a = '0;
        #1 arst = 1'b1;
        repeat (3) @(posedge ck);
        #2 arst = 1'b0;
        cmp_on = 1;

        // Idle after reset
        repeat (20) step();
        check("idle_enable", radio_enable, 2'b00);
        check("idle_ready",  ready,        2'b00);

        // Enable sequence on channel 0
        en_a = 2'b01; rx_a = 2'b01;
        step(); check("seq_en_k",    radio_enable, 2'b00);
        step(); check("seq_en_k1",   radio_enable, 2'b00);
        step(); check("seq_en_k2",   radio_enable, 2'b01);
                check("seq_rise",    enable_rise,  2'b01);
        step(); check("seq_rise_end", enable_rise, 2'b00);
                check("seq_ready_k3", ready,       2'b00);
        step(); step();
                check("seq_ready_k5", ready,       2'b00);
        step(); check("seq_ready_k6", ready,       2'b01);
                check("seq_rx_k6",   radio_rx_en,  2'b01);

        // Drain
        en_a = 2'b00;
        step(); step();
                check("drn_ready_hold", ready,        2'b01);
        step(); check("drn_enable",     radio_enable, 2'b01);
                check("drn_ready",      ready,        2'b00);
                check("drn_rx",         radio_rx_en,  2'b00);
                check("drn_fall",       enable_fall,  2'b01);
        step(); check("drn_enable2",    radio_enable, 2'b01);
                check("drn_fall_end",   enable_fall,  2'b00);
        step(); check("drn_off",        radio_enable, 2'b00);
        repeat (3) step();

        // Abort while settling
        en_a = 2'b01; rx_a = 2'b01;
        step(); step();
        en_a = 2'b00;
        step(); check("abt_enable", radio_enable, 2'b01);
                check("abt_rise",   enable_rise,  2'b01);
        step(); check("abt_rx",     radio_rx_en,  2'b00);
        step(); check("abt_off",    radio_enable, 2'b00);
                check("abt_fall",   enable_fall,  2'b01);
        step(); check("abt_fall_end", enable_fall, 2'b00);
        repeat (3) step();

        // Isolation with both channels on
        en_a = 2'b11; rx_a = 2'b11;
        repeat (8) step();
        check("iso_pre_ready", ready,       2'b11);
        check("iso_pre_rx",    radio_rx_en, 2'b11);
        isolate = 1'b1;
        #1;
        check("iso_enable", radio_enable, 2'b00);
        check("iso_ready",  ready,        2'b00);
        check("iso_rx",     radio_rx_en,  2'b00);
        repeat (5) step();
        check("iso_fall", enable_fall, 2'b00);
        isolate = 1'b0;
        step(); check("iso_rel_enable", radio_enable, 2'b11);
                check("iso_rel_rise",   enable_rise,  2'b11);
        step(); check("iso_rise_end",   enable_rise,  2'b00);
        step(); step();
                check("iso_ready_k3",   ready,        2'b00);
        step(); check("iso_ready_k4",   ready,        2'b11);

        // Re-enable during drain
        en_a = 2'b10;
        step(); step();
                check("red_ready_hold", ready,        2'b11);
        step(); check("red_enable",     radio_enable, 2'b11);
                check("red_ready",      ready,        2'b10);
                check("red_fall",       enable_fall,  2'b01);
        en_a = 2'b11;
        step(); check("red_drain",      radio_enable, 2'b11);
        step(); check("red_off",        radio_enable, 2'b10);
        step(); check("red_settle",     radio_enable, 2'b11);
                check("red_rise",       enable_rise,  2'b01);
        repeat (5) step();
        check("red_ready_back", ready, 2'b11);

        // Reset while on
        arst = 1'b1;
        #1;
        check("rst_enable", radio_enable, 2'b00);
        check("rst_ready",  ready,        2'b00);
        check("rst_fall",   enable_fall,  2'b00);
        step(); check("rst_fall_hold", enable_fall, 2'b00);
        arst = 1'b0;

        // Randomized traffic
        iso_left = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 11) == 0) en_a[c] = ~en_a[c];
                if ($urandom_range(0, 3) == 0)  rx_a[c] = ~rx_a[c];
            end
            if (iso_left > 0) begin
                iso_left--;
                if (iso_left == 0) isolate = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                isolate  = 1'b1;
                iso_left = $urandom_range(1, 6);
            end
        end
        isolate = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
